// File: rtl/bus_arb_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_arb_enc: round-robin arbiter/encoder for a 4-source tri-state bus.     |
// | Optional turnaround cycle between owners: define BUS_ARB_TURNAROUND_EN.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bus_arb_enc #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] cnt,
    output logic       en,
    output logic       timeout
);

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_last;
    logic [7:0] r_hold;

    logic [1:0] w_base;
    logic       w_found;
    logic [1:0] w_win;
    logic       w_owner_req;
    logic       w_at_limit;
    logic       w_release;
    logic       w_forced;

    // On a release in GRANT, the outgoing owner becomes the search origin.
    assign w_base = (r_state == ST_GRANT) ? cnt : r_last;

    // Requester k sits on req[3-k]; search k = base+1 .. base+4 (mod 4).
    always_comb begin
        w_found = 1'b0;
        w_win   = w_base;
        for (int i = 1; i <= 4; i++) begin
            if (!w_found && req[2'd3 - (w_base + 2'(i))]) begin
                w_found = 1'b1;
                w_win   = w_base + 2'(i);
            end
        end
    end

    assign w_owner_req = req[2'd3 - cnt];
    assign w_at_limit  = (r_hold == c_max_hold);
    assign w_release   = done | ~w_owner_req | w_at_limit;
    assign w_forced    = ~done & w_owner_req & w_at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= 2'b11;
            r_hold  <= 8'd0;
            cnt     <= 2'b00;
            en      <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (r_state)
                ST_GRANT: begin
                    if (w_release) begin
                        r_last  <= cnt;
                        timeout <= w_forced;
`ifdef BUS_ARB_TURNAROUND_EN
                        en      <= 1'b0;
                        r_state <= ST_GAP;
`else
                        if (w_found) begin
                            cnt    <= w_win;
                            r_hold <= 8'd1;
                        end else begin
                            en      <= 1'b0;
                            r_state <= ST_IDLE;
                        end
`endif
                    end else if (!w_at_limit) begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: begin
                    // IDLE and GAP behave alike: arbitrate from the last owner.
                    if (w_found) begin
                        cnt     <= w_win;
                        en      <= 1'b1;
                        r_hold  <= 8'd1;
                        r_state <= ST_GRANT;
                    end else begin
                        en      <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arb_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bus_arb_enc: directed + randomized bench with a behavioural model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bus_arb_enc;

    localparam int MAXH = 4;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       done = 1'b0;
    logic [3:0] req  = 4'b0000;
    logic [1:0] cnt;
    logic       en;
    logic       timeout;

    always #5 clk = ~clk;

    bus_arb_enc #(.MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .cnt     (cnt),
        .en      (en),
        .timeout (timeout)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference: owner index, bus busy flag, hold length, round-robin origin.
    int m_cnt  = 0;
    int m_en   = 0;
    int m_to   = 0;
    int m_last = 3;
    int m_hold = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int base, input logic [3:0] r);
        for (int s = 1; s <= 4; s++) begin
            int k;
            k = (base + s) % 4;
            if (r[3 - k]) return k;
        end
        return -1;
    endfunction

    task automatic step(input logic [3:0] r, input logic d, input logic rs);
        int  pick;
        bit  oreq;
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        if (rs) begin
            m_cnt = 0; m_en = 0; m_to = 0; m_last = 3; m_hold = 0;
        end else begin
            m_to = 0;
            if (m_en != 0) begin
                oreq = r[3 - m_cnt];
                if (!d && oreq && m_hold < MAXH) begin
                    m_hold++;
                end else begin
                    m_to   = (!d && oreq) ? 1 : 0;
                    m_last = m_cnt;
`ifdef BUS_ARB_TURNAROUND_EN
                    m_en = 0;
`else
                    pick = rr_pick(m_last, r);
                    if (pick >= 0) begin
                        m_cnt  = pick;
                        m_hold = 1;
                    end else begin
                        m_en = 0;
                    end
`endif
                end
            end else begin
                pick = rr_pick(m_last, r);
                if (pick >= 0) begin
                    m_cnt  = pick;
                    m_en   = 1;
                    m_hold = 1;
                end
            end
        end
        #1;
        chk("cnt", 8'(cnt), 8'(m_cnt));
        chk("en", 8'(en), 8'(m_en));
        chk("timeout", 8'(timeout), 8'(m_to));
    endtask

    initial begin
        logic [3:0] cur_req;
        logic       d;
        logic       rs;

        // Reset state
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk("rst_cnt", 8'(cnt), 8'd0);
        chk("rst_en", 8'(en), 8'd0);
        chk("rst_timeout", 8'(timeout), 8'd0);

        // Single requester 2, then drop
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        chk("single_cnt", 8'(cnt), 8'd2);
        chk("single_en", 8'(en), 8'd1);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk("drop_en", 8'(en), 8'd0);
        chk("drop_cnt", 8'(cnt), 8'd2);

        // Ignored done while idle
        step(4'b0000, 1'b1, 1'b0);
        chk("ign_done_to", 8'(timeout), 8'd0);
        chk("ign_done_cnt", 8'(cnt), 8'd2);

        // Round-robin fairness with done pulsed every cycle
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(4'b1111, 1'b1, 1'b0);

        // Timeout with requester 0 alone
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) step(4'b1000, 1'b0, 1'b0);

        // done coincident with hold at MAX_HOLD is a normal release
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < MAXH - 1; i++) step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        chk("done_at_max_to", 8'(timeout), 8'd0);

        // Mid-grant reset with owner 3
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0001, 1'b0, 1'b0);
        chk("own3_cnt", 8'(cnt), 8'd3);
        step(4'b0001, 1'b0, 1'b1);
        chk("midrst_en", 8'(en), 8'd0);
        chk("midrst_cnt", 8'(cnt), 8'd0);
        step(4'b1001, 1'b0, 1'b0);
        chk("post_rst_cnt", 8'(cnt), 8'd0);
        chk("post_rst_en", 8'(en), 8'd1);

        // Randomized traffic
        cur_req = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) cur_req = 4'($urandom);
            d  = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 199) == 0);
            step(cur_req, d, rs);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arb_enc.md
# bus_arb_enc

- Round-robin arbiter and encoder for the shared 4-source tri-state bus.
- Takes four request lines, picks one owner at a time, and drives the 2-bit select `cnt` and enable `en` that feed the bus select decoder.
- Enforces a maximum ownership time per grant.
- Can optionally insert a bus-idle turnaround cycle between owners to prevent driver overlap.

## Interface

Parameters:
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner holds the bus. Legal range is 1..255.

Ports:
- `clk`  in  1  : single clock, rising edge.
- `rst`  in  1  : synchronous, active-high reset.
- `req`  in  4  : request lines. Requester k (k = 0..3) is `req[3-k]`, matching the decoder mapping (cnt=0 selects bit 3).
- `done` in  1  : the current owner releases the bus. Only meaningful while `en`=1.
- `cnt`  out 2  : index of the current or last owner, to the decoder.
- `en`   out 1  : bus enable, to the decoder. `en`=1 means `cnt` selects an active driver.
- `timeout` out 1 : one-cycle pulse when a grant is force-released by `MAX_HOLD`.

## Operation

- State machine states:
  - IDLE (`en`=0)
  - GRANT (`en`=1)
  - GAP (`en`=0; exists only with the configuration macro)
- Internal registers:
  - `last[1:0]`: round-robin pointer.
  - `hold[7:0]`: ownership counter.
- Arbitration (in IDLE, GAP, or on release without the macro):
  - Search requesters in order (last+1), (last+2), (last+3), (last+4), all mod 4.
  - The first one with its req high wins. This search can return the previous owner if it is the only requester.
- IDLE / GAP:
  - If any req is high, register winner -> `cnt`, set `en`=1, set `hold`=1, go to GRANT.
  - Otherwise go to or stay in IDLE. `cnt` keeps its last value.
- GRANT, release conditions, evaluated each cycle in priority order:
  - (a) `done`=1.
  - (b) the owner's req is low.
  - (c) `hold`==`MAX_HOLD`. Only in this case is `timeout` pulsed, on the next cycle.
- GRANT, no release: increment `hold`. It saturates; it can never exceed `MAX_HOLD`.
- GRANT, on release:
  - Set `last`<=`cnt`.
  - Next state and behaviour depend on the macro (see Configuration).
- `cnt` changes only on the edge where a new grant is issued. It never changes while `en` stays 0.
- Reset (synchronous, any state, including mid-grant):
  - `cnt`=2'b00, `en`=0, `timeout`=0, `last`=2'b11, `hold`=0, state IDLE.
  - The first grant after reset therefore searches from requester 0.

## Timing

- Grant latency: req sampled high in cycle N (bus idle) -> `en`=1 with the winner's `cnt` in cycle N+1.
- Ownership length: `en` stays high for at most exactly `MAX_HOLD` cycles per grant.
- `done` or req-drop observed in cycle N -> the owner's `en`/`cnt` pair ends after cycle N.
- `timeout` is high for exactly the one cycle after the forcing edge. It is never asserted when `done` or req-drop caused the release in the same cycle.
- Simultaneous events:
  - `done` together with `hold`==`MAX_HOLD` counts as a normal release, with no `timeout`.
  - Multiple new requests in the same cycle are resolved purely by round-robin order.
- `done` while `en`=0 is ignored.
- `req` changes during GAP are sampled in the GAP cycle itself.

## Configuration

- Macro: `BUS_ARB_TURNAROUND_EN`.
- Defined:
  - Every release goes to GAP for exactly one cycle with `en`=0.
  - Arbitration happens in GAP. Release at cycle N -> `en`=0 at N+1 -> next grant `en`=1 at N+2.
  - `cnt` never changes while `en`=1.
- Undefined:
  - No GAP state.
  - On release, arbitrate in the same cycle. If there is a winner, stay in GRANT with the new `cnt`, `en` held at 1, and `hold`=1 (back-to-back handover with no idle cycle).
  - If there is no winner, go to IDLE with `en`=0 on the next cycle.

## Test plan

- Reset then single requester: `req`=4'b0010 at cycle 5 -> cycle 6 shows `cnt`=2, `en`=1. Drop req at cycle 9 -> `en`=0 at cycle 10, `cnt` stays 2.
- Round-robin fairness: `req`=4'b1111 held, `done` pulsed each grant -> grant order `cnt`=0,1,2,3,0. With the macro, an `en`=0 cycle appears between each grant; without it, `en` stays 1 continuously.
- Timeout: `MAX_HOLD`=4, `req`=4'b1000 held alone, no `done` -> `en` high exactly 4 cycles, then `timeout`=1 for one cycle, then requester 0 is re-granted (after GAP with the macro).
- Simultaneous `done` at `hold`==`MAX_HOLD` -> release with `timeout`=0.
- Mid-grant reset: `rst`=1 during GRANT with `cnt`=3 -> next cycle `en`=0, `cnt`=0. Next grant with `req`=4'b1001 goes to requester 0.
- Ignored `done`: `done`=1 with `en`=0 and `req`=0 -> outputs unchanged, no `timeout`.
